// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS main controller FSM
// Sequences fetch/decode/execute/write-back over the shared ALU and memory port.
module mc_controller #(
  parameter bit OVF_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       ovf_trap,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB   = 4'd4,  MEMWR   = 4'd5,  EXECUTE = 4'd6, ALUWB  = 4'd7,
    BRANCH  = 4'd8,  ADDIEX  = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;

  state_t state_q, state_d;
  logic   ovf_q, ovf_d;
  logic   pcwrite, branch, trap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  assign state = state_q;
  assign trap  = OVF_TRAP && ovf_q;

  always_comb begin
    state_d    = FETCH;
    ovf_d      = ovf_q;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = 3'b010;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    ovf_trap   = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        ovf_d   = 1'b0;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        state_d  = mem_ready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        case (funct)
          F_ADD:     alucontrol = 3'b010;
          F_SUB:     alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
        // Only add/sub can trap; logical ops and slt never suppress write-back.
        ovf_d   = (funct == F_ADD || funct == F_SUB) ? overflow : 1'b0;
        state_d = ALUWB;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = ~trap;
        ovf_trap = trap;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        branch     = 1'b1;
        pcsrc      = 2'b01;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        ovf_d   = overflow;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regwrite = ~trap;
        ovf_trap = trap;
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    // Reset abandons the instruction: no strobe may escape during it.
    if (rst) begin
      memwrite = 1'b0;
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      regwrite = 1'b0;
      ovf_trap = 1'b0;
      illegal  = 1'b0;
    end
    pcen = pcwrite | (branch & zero);
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - randomized self-checking bench for mc_controller
// Two instances (trap on / trap off) share stimulus; expectations come from an instruction-path model.
module tb_mc_controller;

  typedef struct packed {
    logic       iord, memwrite, irwrite, pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluc;
    logic       regdst, memtoreg, regwrite, ovf_trap, illegal;
  } ctrl_t;
  typedef int iq_t[$];

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [5:0] FADD = 6'b100000, FSUB = 6'b100010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, zero = 1'b0, overflow = 1'b0, mem_ready = 1'b0;
  logic [5:0] op = 6'd0, funct = 6'd0;

  logic iord_a, memwrite_a, irwrite_a, pcen_a, alusrca_a, regdst_a, memtoreg_a, regwrite_a, ovf_trap_a, illegal_a;
  logic iord_b, memwrite_b, irwrite_b, pcen_b, alusrca_b, regdst_b, memtoreg_b, regwrite_b, ovf_trap_b, illegal_b;
  logic [1:0] pcsrc_a, alusrcb_a, pcsrc_b, alusrcb_b;
  logic [2:0] alucontrol_a, alucontrol_b;
  logic [3:0] state_a, state_b;

  mc_controller #(.OVF_TRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .overflow(overflow),
    .mem_ready(mem_ready), .iord(iord_a), .memwrite(memwrite_a), .irwrite(irwrite_a),
    .pcen(pcen_a), .pcsrc(pcsrc_a), .alusrca(alusrca_a), .alusrcb(alusrcb_a),
    .alucontrol(alucontrol_a), .regdst(regdst_a), .memtoreg(memtoreg_a),
    .regwrite(regwrite_a), .ovf_trap(ovf_trap_a), .illegal(illegal_a), .state(state_a));

  mc_controller #(.OVF_TRAP(1'b0)) dut_notrap (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .overflow(overflow),
    .mem_ready(mem_ready), .iord(iord_b), .memwrite(memwrite_b), .irwrite(irwrite_b),
    .pcen(pcen_b), .pcsrc(pcsrc_b), .alusrca(alusrca_b), .alusrcb(alusrcb_b),
    .alucontrol(alucontrol_b), .regdst(regdst_b), .memtoreg(memtoreg_b),
    .regwrite(regwrite_b), .ovf_trap(ovf_trap_b), .illegal(illegal_b), .state(state_b));

  ctrl_t obs_a, obs_b;
  assign obs_a = {iord_a, memwrite_a, irwrite_a, pcen_a, pcsrc_a, alusrca_a, alusrcb_a,
                  alucontrol_a, regdst_a, memtoreg_a, regwrite_a, ovf_trap_a, illegal_a};
  assign obs_b = {iord_b, memwrite_b, irwrite_b, pcen_b, pcsrc_b, alusrca_b, alusrcb_b,
                  alucontrol_b, regdst_b, memtoreg_b, regwrite_b, ovf_trap_b, illegal_b};

  int checks = 0, errors = 0;
  int   tr_st[$];
  ctrl_t tr_a[$], tr_b[$];

  function automatic bit is_legal(input logic [5:0] o);
    return o inside {LW, SW, RT, BEQ, ADDI, JMP};
  endfunction

  // State walk of one instruction with memory always ready.
  function automatic iq_t path_of(input logic [5:0] o);
    case (o)
      LW:      return '{0, 1, 2, 3, 4};
      SW:      return '{0, 1, 2, 5};
      RT:      return '{0, 1, 6, 7};
      BEQ:     return '{0, 1, 8};
      ADDI:    return '{0, 1, 9, 10};
      JMP:     return '{0, 1, 11};
      default: return '{0, 1};
    endcase
  endfunction

  function automatic ctrl_t exp_ctrl(input int st, input logic rdy, input logic z, input logic trap,
                                     input logic [5:0] f, input logic [5:0] o);
    ctrl_t c;
    c = '0;
    c.aluc = 3'b010;
    case (st)
      0:  begin c.alusrcb = 2'b01; c.irwrite = rdy; c.pcen = rdy; end
      1:  begin c.alusrcb = 2'b11; c.illegal = !is_legal(o); end
      2:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      3:  c.iord = 1'b1;
      4:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      5:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
      6:  begin
        c.alusrca = 1'b1;
        c.aluc = (f == FADD) ? 3'b010 : (f == FSUB) ? 3'b110 : (f == 6'b100100) ? 3'b000 :
                 (f == 6'b100101) ? 3'b001 : (f == 6'b101010) ? 3'b111 : 3'b010;
      end
      7:  begin c.regdst = 1'b1; c.regwrite = !trap; c.ovf_trap = trap; end
      8:  begin c.alusrca = 1'b1; c.aluc = 3'b110; c.pcsrc = 2'b01; c.pcen = z; end
      9:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      10: begin c.regwrite = !trap; c.ovf_trap = trap; end
      11: begin c.pcsrc = 2'b10; c.pcen = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic drive(input logic r, input logic rdy, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic v);
    @(posedge clk);
    #1;
    rst = r; mem_ready = rdy; op = o; funct = f; zero = z; overflow = v;
    @(negedge clk);
  endtask

  // Runs one instruction starting in FETCH, comparing every cycle with the path model.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z, input logic v,
                           input int maxwait);
    iq_t p;
    logic ovf_flag, rdy;
    int nwait;
    ctrl_t ea, eb;
    p = path_of(o);
    ovf_flag = v && ((o == RT && (f == FADD || f == FSUB)) || o == ADDI);
    tr_st.delete(); tr_a.delete(); tr_b.delete();
    foreach (p[i]) begin
      nwait = (p[i] inside {0, 3, 5}) ? $urandom_range(maxwait, 0) : 0;
      for (int w = 0; w <= nwait; w++) begin
        rdy = (p[i] inside {0, 3, 5}) ? (w == nwait) : 1'($urandom_range(1, 0));
        drive(1'b0, rdy, o, f, z, v);
        tr_st.push_back(int'(state_a)); tr_a.push_back(obs_a); tr_b.push_back(obs_b);
        ea = exp_ctrl(p[i], rdy, z, ovf_flag, f, o);
        eb = exp_ctrl(p[i], rdy, z, 1'b0, f, o);
        checks++;
        if (state_a !== 4'(p[i]) || state_b !== 4'(p[i])) begin
          errors++;
          $display("FAIL state op=%b: got %0d/%0d expected %0d", o, state_a, state_b, p[i]);
        end
        checks++;
        if (obs_a !== ea) begin
          errors++;
          $display("FAIL ctrl_trap op=%b st=%0d: got %h expected %h", o, p[i], obs_a, ea);
        end
        checks++;
        if (obs_b !== eb) begin
          errors++;
          $display("FAIL ctrl_notrap op=%b st=%0d: got %h expected %h", o, p[i], obs_b, eb);
        end
      end
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, LW, FADD, 1'b1, 1'b0);
      checks++;
      if ({memwrite_a, irwrite_a, pcen_a, regwrite_a, ovf_trap_a, illegal_a} !== 6'b0) begin
        errors++;
        $display("FAIL reset_strobes: got %b expected 000000",
                 {memwrite_a, irwrite_a, pcen_a, regwrite_a, ovf_trap_a, illegal_a});
      end
    end
    checks++;
    if (state_a !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_a); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, i == 3, 6'b111111, 6'd0, 1'b0, 1'b0);
      checks++;
      if (state_a !== 4'd0 || irwrite_a !== (i == 3) || pcen_a !== (i == 3) || alusrcb_a !== 2'b01
          || alucontrol_a !== 3'b010) begin
        errors++;
        $display("FAIL fetch_wait%0d: got st=%0d ir=%b pcen=%b srcb=%b alu=%b expected st=0 ir=pcen=%0d srcb=01 alu=010",
                 i, state_a, irwrite_a, pcen_a, alusrcb_a, alucontrol_a, i == 3);
      end
    end
    drive(1'b0, 1'b1, 6'b111111, 6'd0, 1'b0, 1'b0);
    checks++;
    if (state_a !== 4'd1 || illegal_a !== 1'b1) begin
      errors++; $display("FAIL fetch_to_decode: got st=%0d ill=%b expected st=1 ill=1", state_a, illegal_a);
    end
  endtask

  task automatic test_lw_sw;
    int nreg;
    run_instr(LW, 6'd0, 1'b0, 1'b0, 0);
    checks++;
    if (tr_st.size() != 5 || tr_st[4] != 4) begin
      errors++; $display("FAIL lw_path: got len %0d expected 5", tr_st.size());
    end
    nreg = 0;
    foreach (tr_a[i]) if (tr_a[i].regwrite) nreg += (tr_a[i].memtoreg && tr_st[i] == 4) ? 1 : 100;
    checks++;
    if (nreg != 1) begin errors++; $display("FAIL lw_regwrite: got %0d expected 1", nreg); end
    run_instr(SW, 6'd0, 1'b0, 1'b0, 0);
    nreg = 0;
    foreach (tr_a[i]) if (tr_a[i].memwrite) nreg += (tr_st[i] == 5) ? 1 : 100;
    checks++;
    if (nreg != 1) begin errors++; $display("FAIL sw_memwrite: got %0d expected 1", nreg); end
  endtask

  task automatic test_rtype_sub;
    run_instr(RT, FSUB, 1'b0, 1'b0, 0);
    checks++;
    if (tr_a[2].aluc !== 3'b110 || tr_a[3].regwrite !== 1'b1 || tr_a[3].regdst !== 1'b1 ||
        tr_a[3].ovf_trap !== 1'b0) begin
      errors++;
      $display("FAIL rtype_sub: got alu=%b rw=%b rd=%b trap=%b expected 110 1 1 0",
               tr_a[2].aluc, tr_a[3].regwrite, tr_a[3].regdst, tr_a[3].ovf_trap);
    end
  endtask

  task automatic test_addi_ovf;
    run_instr(ADDI, 6'($urandom), 1'b0, 1'b1, 0);
    checks++;
    if (tr_a[3].regwrite !== 1'b0 || tr_a[3].ovf_trap !== 1'b1) begin
      errors++; $display("FAIL addi_trap_on: got rw=%b trap=%b expected 0 1", tr_a[3].regwrite, tr_a[3].ovf_trap);
    end
    checks++;
    if (tr_b[3].regwrite !== 1'b1 || tr_b[3].ovf_trap !== 1'b0) begin
      errors++; $display("FAIL addi_trap_off: got rw=%b trap=%b expected 1 0", tr_b[3].regwrite, tr_b[3].ovf_trap);
    end
  endtask

  task automatic test_beq_j;
    for (int z = 1; z >= 0; z--) begin
      run_instr(BEQ, 6'd0, 1'(z), 1'b0, 0);
      checks++;
      if (tr_st[2] != 8 || tr_a[2].pcen !== 1'(z) || tr_a[2].pcsrc !== 2'b01) begin
        errors++;
        $display("FAIL beq_z%0d: got st=%0d pcen=%b pcsrc=%b expected 8 %0d 01", z, tr_st[2], tr_a[2].pcen, tr_a[2].pcsrc, z);
      end
    end
    run_instr(JMP, 6'd0, 1'b0, 1'b0, 0);
    checks++;
    if (tr_st[2] != 11 || tr_a[2].pcen !== 1'b1 || tr_a[2].pcsrc !== 2'b10) begin
      errors++; $display("FAIL jump: got st=%0d pcen=%b pcsrc=%b expected 11 1 10", tr_st[2], tr_a[2].pcen, tr_a[2].pcsrc);
    end
  endtask

  task automatic test_illegal_midreset;
    run_instr(6'b111111, 6'd0, 1'b0, 1'b0, 0);
    checks++;
    if (tr_a[1].illegal !== 1'b1) begin errors++; $display("FAIL illegal: got %b expected 1", tr_a[1].illegal); end
    drive(1'b0, 1'b1, SW, 6'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, SW, 6'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, SW, 6'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, SW, 6'd0, 1'b0, 1'b0);
    checks++;
    if (state_a !== 4'd5 || memwrite_a !== 1'b1) begin
      errors++; $display("FAIL memwr_wait: got st=%0d mw=%b expected 5 1", state_a, memwrite_a);
    end
    drive(1'b1, 1'b0, SW, 6'd0, 1'b0, 1'b0);
    checks++;
    if (memwrite_a !== 1'b0 || memwrite_b !== 1'b0) begin
      errors++; $display("FAIL reset_memwrite: got %b/%b expected 0", memwrite_a, memwrite_b);
    end
    drive(1'b0, 1'b1, 6'b111111, 6'd0, 1'b0, 1'b0);
    checks++;
    if (state_a !== 4'd0 || memwrite_a !== 1'b0 || irwrite_a !== 1'b1) begin
      errors++; $display("FAIL midreset_fetch: got st=%0d mw=%b ir=%b expected 0 0 1", state_a, memwrite_a, irwrite_a);
    end
    drive(1'b0, 1'b1, 6'b111111, 6'd0, 1'b0, 1'b0);
    checks++;
    if (state_a !== 4'd1) begin errors++; $display("FAIL midreset_decode: got %0d expected 1", state_a); end
  endtask

  task automatic test_random;
    logic [5:0] ops[7];
    logic [5:0] fns[6];
    logic [5:0] o, f;
    ops = '{LW, SW, RT, BEQ, ADDI, JMP, 6'd0};
    fns = '{FADD, FSUB, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    for (int n = 0; n < 60; n++) begin
      o = ops[$urandom_range(6, 0)];
      if (n % 7 == 6) begin
        o = 6'($urandom);
        while (is_legal(o)) o = 6'($urandom);
      end
      f = fns[$urandom_range(5, 0)];
      run_instr(o, f, 1'($urandom), 1'($urandom), 3);
    end
  endtask

  initial begin
    test_reset;
    test_lw_sw;
    test_rtype_sub;
    test_addi_ovf;
    test_beq_j;
    test_illegal_midreset;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
